// File: rtl/gb_conv_arbiter_pkg.sv
// Shared definitions for the Gray-to-binary conversion arbiter:
// parameter defaults, slot state encoding and an index-width helper.
package gb_conv_arbiter_pkg;

   localparam int NREQ_DEFAULT = 4;
   localparam int W_DEFAULT    = 4;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< result) < value) begin
            result = result + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/gb_conv_arbiter_gray2bin_w.sv
// Purely combinational W-bit Gray-to-binary converter (prefix XOR from the MSB down).
module gray2bin_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // running XOR of all Gray bits at or above the current position
   always_comb begin
      logic acc_s;
      acc_s = 1'b0;
      bin   = {W{1'b0}};
      for (int k = W - 1; k >= 0; k--) begin
         acc_s  = acc_s ^ gray[k];
         bin[k] = acc_s;
      end
   end

endmodule

// File: rtl/gb_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ requesters,
// with a one-entry tagged output slot and valid/ready handshakes on both sides.
module gb_conv_arbiter
   import gb_conv_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int W    = W_DEFAULT,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_gray,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_bin,
   output logic [IDW-1:0]    out_id,
   input  logic              out_ready
);

   slot_state_e    state_r;
   slot_state_e    state_next_s;
   logic [IDW-1:0] last_r;
   logic [IDW-1:0] gnt_idx_s;
   logic           gnt_found_s;
   logic           slot_free_s;
   logic           xfer_s;
   logic [W-1:0]   sel_gray_s;
   logic [W-1:0]   conv_bin_s;
   logic [W-1:0]   out_bin_r;
   logic [IDW-1:0] out_id_r;

   assign slot_free_s = (state_r == SLOT_EMPTY) || out_ready;

   // round-robin search starting just above the last granted index
   always_comb begin
      int idx_v;
      gnt_found_s = 1'b0;
      gnt_idx_s   = {IDW{1'b0}};
      idx_v       = 0;
      for (int off = 1; off <= NREQ; off++) begin
         idx_v = (int'(last_r) + off) % NREQ;
         if (!gnt_found_s && req_valid[idx_v]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = IDW'(idx_v);
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // ready is gated by reset so no grant can be seen while rst_n is low
   always_comb begin
      if (rst_n && slot_free_s && gnt_found_s) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   assign xfer_s     = |(req_ready & req_valid);
   assign sel_gray_s = req_gray[int'(gnt_idx_s)*W +: W];

   gray2bin_w #(.W(W)) u_gray2bin (
      .gray (sel_gray_s),
      .bin  (conv_bin_s)
   );

   // output slot next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         SLOT_EMPTY: begin
            if (xfer_s) state_next_s = SLOT_FULL;
            else        state_next_s = SLOT_EMPTY;
         end
         SLOT_FULL: begin
            if (xfer_s)         state_next_s = SLOT_FULL;
            else if (out_ready) state_next_s = SLOT_EMPTY;
            else                state_next_s = SLOT_FULL;
         end
         default: state_next_s = SLOT_EMPTY;
      endcase
   end

   // slot state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= SLOT_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // result, tag and priority pointer only move on a transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bin_r <= {W{1'b0}};
         out_id_r  <= {IDW{1'b0}};
         last_r    <= IDW'(NREQ - 1);
      end else if (xfer_s) begin
         out_bin_r <= conv_bin_s;
         out_id_r  <= gnt_idx_s;
         last_r    <= gnt_idx_s;
      end else begin
         out_bin_r <= out_bin_r;
         out_id_r  <= out_id_r;
         last_r    <= last_r;
      end
   end

   assign out_valid = (state_r == SLOT_FULL);
   assign out_bin   = out_bin_r;
   assign out_id    = out_id_r;

endmodule

// File: tb/tb_gb_conv_arbiter.sv
// Directed self-checking bench for gb_conv_arbiter (NREQ=4, W=4).
module tb_gb_conv_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_gray;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [3:0]  out_bin;
   logic [1:0]  out_id;
   logic        out_ready;

   int checks_cnt;
   int errors_cnt;

   gb_conv_arbiter #(.NREQ(4), .W(4), .IDW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_gray  (req_gray),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_bin   (out_bin),
      .out_id    (out_id),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt = checks_cnt + 1;
      if (obs !== exp) begin
         errors_cnt = errors_cnt + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; inputs and checks happen off-edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      out_ready = 1'b0;
      #2;
      check_val("rst_ready", 32'(req_ready), 32'h0);
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b0000;
   endtask

   function automatic logic [3:0] ref_bin(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   logic [3:0] rot_gray [4];
   logic [3:0] rot_bin  [4];
   logic [3:0] g_v;

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      rst_n      = 1'b0;
      req_valid  = 4'b0000;
      req_gray   = 16'h0000;
      out_ready  = 1'b0;
      rot_gray   = '{4'b0110, 4'b1000, 4'b0001, 4'b1111};
      rot_bin    = '{4'b0100, 4'b1111, 4'b0001, 4'b1010};

      // reset state
      do_reset();
      check_val("rst_out_valid", 32'(out_valid), 32'h0);
      check_val("rst_out_bin",   32'(out_bin),   32'h0);
      check_val("rst_out_id",    32'(out_id),    32'h0);

      // single request from requester 0
      req_gray[3:0] = 4'b1011;
      req_valid     = 4'b0001;
      #1;
      check_val("single_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      #1;
      check_val("single_valid", 32'(out_valid), 32'h1);
      check_val("single_bin",   32'(out_bin),   32'hD);
      check_val("single_id",    32'(out_id),    32'h0);
      check_val("single_full_ready", 32'(req_ready), 32'h0);
      out_ready = 1'b1;
      tick();
      check_val("single_drained", 32'(out_valid), 32'h0);

      // rotation with all requesters valid
      do_reset();
      for (int i = 0; i < 4; i++) req_gray[i*4 +: 4] = rot_gray[i];
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         #1;
         check_val("rot_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
         tick();
         check_val("rot_valid", 32'(out_valid), 32'h1);
         check_val("rot_id",    32'(out_id),    32'(n % 4));
         check_val("rot_bin",   32'(out_bin),   32'(rot_bin[n % 4]));
      end
      req_valid = 4'b0000;
      tick();

      // backpressure with requester 2 (last grant was 0)
      out_ready = 1'b0;
      req_valid = 4'b0100;
      #1;
      check_val("bp_first_ready", 32'(req_ready), 32'h4);
      tick();
      req_gray[11:8] = 4'b1100;
      for (int n = 0; n < 5; n++) begin
         #1;
         check_val("bp_ready_zero", 32'(req_ready), 32'h0);
         check_val("bp_valid",      32'(out_valid), 32'h1);
         check_val("bp_bin_stable", 32'(out_bin),   32'h1);
         check_val("bp_id_stable",  32'(out_id),    32'h2);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_release_ready", 32'(req_ready), 32'h4);
      tick();
      check_val("bp_next_valid", 32'(out_valid), 32'h1);
      check_val("bp_next_bin",   32'(out_bin),   32'h8);
      check_val("bp_next_id",    32'(out_id),    32'h2);

      // priority retention: grant 1, then 0 and 3 compete
      req_valid = 4'b0010;
      #1;
      check_val("prio_grant1", 32'(req_ready), 32'h2);
      tick();
      check_val("prio_id1", 32'(out_id), 32'h1);
      req_valid = 4'b1001;
      #1;
      check_val("prio_grant3", 32'(req_ready), 32'h8);
      tick();
      check_val("prio_id3",  32'(out_id),  32'h3);
      check_val("prio_bin3", 32'(out_bin), 32'hA);
      req_valid = 4'b0001;
      #1;
      check_val("prio_grant0", 32'(req_ready), 32'h1);
      tick();
      check_val("prio_id0",  32'(out_id),  32'h0);
      check_val("prio_bin0", 32'(out_bin), 32'h4);
      req_valid = 4'b0000;
      out_ready = 1'b0;
      tick();
      check_val("prio_held", 32'(out_valid), 32'h1);

      // asynchronous reset while the slot is full
      req_gray[7:4] = 4'b0011;
      tick();
      #2;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      #1;
      check_val("midrst_valid", 32'(out_valid), 32'h0);
      check_val("midrst_bin",   32'(out_bin),   32'h0);
      check_val("midrst_id",    32'(out_id),    32'h0);
      check_val("midrst_ready", 32'(req_ready), 32'h0);
      tick();
      check_val("midrst_held_valid", 32'(out_valid), 32'h0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check_val("midrst_prio0", 32'(req_ready), 32'h1);
      req_valid = 4'b0000;
      tick();

      // exhaustive conversion through requester 3
      req_valid = 4'b1000;
      out_ready = 1'b1;
      for (int g = 0; g < 16; g++) begin
         g_v             = 4'(g);
         req_gray[15:12] = g_v;
         #1;
         check_val("exh_ready", 32'(req_ready), 32'h8);
         tick();
         check_val("exh_id",  32'(out_id),  32'h3);
         check_val("exh_bin", 32'(out_bin), 32'(ref_bin(g_v)));
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
